// File: rtl/spectrum_frame_writer.sv
// Purpose: turns streamed complex FFT bins into approximate magnitudes, fills a back buffer
//          and publishes complete frames to the front buffer that the bar-graph reader uses.
// Latency: the last beat accepted at edge k makes freq_samples/fft_done update at edge k+1.
// Backpressure: s_ready drops only during the single SWAP cycle and depends on state alone.
// Ports:
//   clk_50MHz, rst (async, active-low)
//   s_valid/s_ready/s_re/s_im/s_last : bin stream, one bin per accepted beat
//   freq_samples[0:N-1]              : front-buffer magnitudes, stable between swaps
//   fft_done / frame_err             : 1-cycle pulses for publish / discarded frame
//   frame_cnt                        : published frame counter, wraps at 256
module spectrum_frame_writer #(
  parameter int WIDTH = 12,
  parameter int N     = 256
) (
  input  logic                    clk_50MHz,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH:0]   s_re,
  input  logic signed [WIDTH:0]   s_im,
  input  logic                    s_last,
  output logic        [WIDTH+1:0] freq_samples [0:N-1],
  output logic                    fft_done,
  output logic                    frame_err,
  output logic        [7:0]       frame_cnt
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  typedef enum logic [1:0] {FILL, SWAP, DROP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       idx;
  logic [WIDTH+1:0]    back [0:N-1];

  logic                acc;
  logic                fill_acc;
  logic                at_end;
  logic [WIDTH:0]      a_mag;
  logic [WIDTH:0]      b_mag;
  logic [WIDTH:0]      mx;
  logic [WIDTH:0]      mn;
  logic [WIDTH+1:0]    mag;

  assign acc      = s_valid & s_ready;
  assign fill_acc = acc & (state == FILL);
  assign at_end   = (idx == IDX_MAX);

  // Negating -2^WIDTH wraps back to the same bit pattern, which read unsigned is 2^WIDTH.
  always_comb begin
    a_mag = s_re[WIDTH] ? $unsigned(-s_re) : $unsigned(s_re);
    b_mag = s_im[WIDTH] ? $unsigned(-s_im) : $unsigned(s_im);
    if (a_mag >= b_mag) begin
      mx = a_mag;
      mn = b_mag;
    end else begin
      mx = b_mag;
      mn = a_mag;
    end
    mag = {1'b0, mx} + {2'b00, mn[WIDTH:1]};
  end

  // State register
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (acc && at_end) state_nxt = s_last ? SWAP : DROP;
      end
      SWAP:    state_nxt = FILL;
      DROP: begin
        if (acc && s_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Output logic
  always_comb begin
    s_ready = (state != SWAP);
  end

  // Any s_last or a full count ends the current fill; idx is already 0 by the time DROP exits.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (fill_acc) begin
      idx <= (s_last || at_end) ? '0 : idx + 1'b1;
    end
  end

  // Back buffer needs no reset; a frame only reaches the front after a full N-beat fill.
  always_ff @(posedge clk_50MHz) begin
    if (fill_acc) back[idx] <= mag;
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      freq_samples <= '{default: '0};
      fft_done     <= 1'b0;
      frame_err    <= 1'b0;
      frame_cnt    <= 8'd0;
    end else begin
      fft_done  <= (state == SWAP);
      // Error when s_last and the full count disagree: early end or missing end.
      frame_err <= fill_acc & (s_last ^ at_end);
      if (state == SWAP) begin
        freq_samples <= back;
        frame_cnt    <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
